// File: rtl/tx_serial_7o1_uart.sv
`default_nettype none
// ============================================================================
//  Module      : tx_serial_7o1_uart
//  Description : Asynchronous serial transmitter, 7 data bits, odd parity,
//                1 stop bit (7O1). One frame per accepted partida request;
//                pronto pulses once after the stop bit has been sent.
//  Revision    : 1.0 - initial release
// ============================================================================
module tx_serial_7o1_uart #(
    parameter int BIT_CYCLES = 434
) (
    input  logic       clock,
    input  logic       reset,
    input  logic       partida,
    input  logic [6:0] dados_ascii,
    output logic       saida_serial,
    output logic       pronto,
    output logic       ocupado,
    output logic [3:0] db_estado
);

    localparam int                   c_TIMER_W    = (BIT_CYCLES > 1) ? $clog2(BIT_CYCLES) : 1;
    localparam logic [c_TIMER_W-1:0] c_TIMER_LAST = c_TIMER_W'(BIT_CYCLES - 1);
    localparam logic [3:0]           c_LAST_BIT   = 4'd9;

    typedef enum logic [3:0] {
        REPOUSO     = 4'd0,
        TRANSMISSAO = 4'd1,
        FINAL       = 4'd2
    } state_t;

    state_t                 r_state;
    state_t                 w_next_state;
    logic [9:0]             r_shift;
    logic [9:0]             w_shift_next;
    logic [9:0]             w_frame;
    logic [c_TIMER_W-1:0]   r_timer;
    logic [3:0]             r_bit_cnt;
    logic                   r_serial;
    logic                   w_load;
    logic                   w_bit_wrap;
    logic                   w_parity;

    // Frame layout, LSB first on the line: start, d[0..6], odd parity, stop.
    assign w_parity   = ~^dados_ascii;
    assign w_frame    = {1'b1, w_parity, dados_ascii, 1'b0};
    assign w_bit_wrap = (r_state == TRANSMISSAO) && (r_timer == c_TIMER_LAST);

    // Next-state logic and frame-load decision.
    always_comb begin
        w_next_state = r_state;
        w_load       = 1'b0;
        case (r_state)
            REPOUSO: begin
                if (partida) begin
                    w_load       = 1'b1;
                    w_next_state = TRANSMISSAO;
                end
            end
            TRANSMISSAO: begin
                if (w_bit_wrap && (r_bit_cnt == c_LAST_BIT)) begin
                    w_next_state = FINAL;
                end
            end
            FINAL: begin
                // The edge leaving FINAL is the edge at which REPOUSO is
                // reached; a request present there starts the next frame
                // directly, so the FINAL cycle is the single idle-high gap.
                if (partida) begin
                    w_load       = 1'b1;
                    w_next_state = TRANSMISSAO;
                end else begin
                    w_next_state = REPOUSO;
                end
            end
            default: begin
                w_next_state = REPOUSO;
            end
        endcase
    end

    // Next shift-register contents: load on acceptance, shift on bit wrap.
    always_comb begin
        w_shift_next = r_shift;
        if (w_load) begin
            w_shift_next = w_frame;
        end else if (w_bit_wrap) begin
            w_shift_next = {1'b1, r_shift[9:1]};
        end
    end

    // State register.
    always_ff @(posedge clock) begin
        if (reset) begin
            r_state <= REPOUSO;
        end else begin
            r_state <= w_next_state;
        end
    end

    // Bit timer and bit counter; both idle at zero outside a frame.
    always_ff @(posedge clock) begin
        if (reset || w_load || (r_state != TRANSMISSAO)) begin
            r_timer   <= '0;
            r_bit_cnt <= '0;
        end else if (w_bit_wrap) begin
            r_timer   <= '0;
            r_bit_cnt <= (r_bit_cnt == c_LAST_BIT) ? 4'd0 : r_bit_cnt + 4'd1;
        end else begin
            r_timer   <= r_timer + 1'b1;
        end
    end

    // Shift register and registered line driver; line idles high.
    always_ff @(posedge clock) begin
        if (reset) begin
            r_shift  <= '1;
            r_serial <= 1'b1;
        end else begin
            r_shift  <= w_shift_next;
            r_serial <= (w_next_state == TRANSMISSAO) ? w_shift_next[0] : 1'b1;
        end
    end

    assign saida_serial = r_serial;
    assign pronto       = (r_state == FINAL);
    assign ocupado      = (r_state != REPOUSO);
    assign db_estado    = r_state;

endmodule
`default_nettype wire
